dma_burst_buffer: RTL

- Store-and-forward beat buffer inside the DMA datapath, between the AXI master read-data channel (R) and the AXI master write-data channel (W).
- Captures beats returned from a read burst (for example 16 words from slave mem at 0x400) and replays them as W beats with w_last aligned to the original r_last boundaries.
- Guarantees w_valid never drops mid-burst, unless a single burst is longer than DEPTH.

---
 rtl/dma_burst_buffer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dma_burst_buffer.sv
// Store-and-forward beat buffer between AXI R and W channels; replays read bursts as write bursts.
// Optional statistics counters are built when DMA_BURST_BUFFER_STATS_EN is defined.
module dma_burst_buffer #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 2,
    parameter int unsigned DEPTH          = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [AXI_ID_WIDTH-1:0]       r_id,
    input  logic [AXI_DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                    r_resp,
    input  logic                          r_last,
    input  logic                          r_valid,
    output logic                          r_ready,
    output logic [AXI_DATA_WIDTH-1:0]     w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    output logic                          w_last,
    output logic                          w_valid,
    input  logic                          w_ready,
    output logic [$clog2(DEPTH):0]        level,
    output logic [$clog2(DEPTH):0]        bursts_pending,
    output logic                          err,
    input  logic                          err_clr,
    output logic [31:0]                   beat_cnt,
    output logic [31:0]                   burst_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [AXI_DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]          last_mem;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] bursts_q, bursts_d;
    logic             err_q, err_d;

    logic push;
    logic pop;
    logic burst_in;
    logic burst_out;
    logic head_last;

    // The ID is accepted for protocol completeness but never stored.
    logic unused_r_id;
    assign unused_r_id = ^r_id;

    assign head_last = last_mem[rd_ptr_q];

    always_comb begin
        r_ready = rst_n & ~flush & (level_q != FULL_LEVEL);
        // Full buffer with no complete burst means one burst exceeds DEPTH: cut through.
        w_valid = rst_n & ~flush & (level_q != '0) &
                  ((bursts_q != '0) | (level_q == FULL_LEVEL));
        w_data  = rst_n ? data_mem[rd_ptr_q] : '0;
        w_last  = rst_n & head_last;
        w_strb  = '1;
    end

    assign push      = r_valid & r_ready;
    assign pop       = w_valid & w_ready;
    assign burst_in  = push & r_last;
    assign burst_out = pop & head_last & (bursts_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        bursts_d = bursts_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            bursts_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
            if (burst_in && !burst_out) begin
                bursts_d = bursts_q + LVL_W'(1);
            end else if (burst_out && !burst_in) begin
                bursts_d = bursts_q - LVL_W'(1);
            end
        end
    end

    // A new error beat wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (push && (r_resp != 2'b00)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            bursts_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            bursts_q <= bursts_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= r_data;
            last_mem[wr_ptr_q] <= r_last;
        end
    end

    assign level          = level_q;
    assign bursts_pending = bursts_q;
    assign err            = err_q;

`ifdef DMA_BURST_BUFFER_STATS_EN
    logic [31:0] beat_cnt_q;
    logic [31:0] burst_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            if (push) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (pop && head_last) begin
                burst_cnt_q <= burst_cnt_q + 32'd1;
            end
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign burst_cnt = burst_cnt_q;
`else
    assign beat_cnt  = '0;
    assign burst_cnt = '0;
`endif

endmodule
